// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder sequencer.
// The sequencer uses the slave view; whoever supplies operands and consumes
// results uses the master view.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer. It feeds an external 1-bit full_adder cell one
// operand bit pair per clock, LSB first. The carry loops back through
// carry_reg. The collected sum and final carry are presented on a valid/ready
// output. fa_* are driven only from registers, so no input reaches them
// combinationally.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus,
    output logic                busy,
    output logic                fa_a,
    output logic                fa_b,
    output logic                fa_cin,
    input  logic                fa_s,
    input  logic                fa_cout
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             shift_en;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        shift_en      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (cnt == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, serial shifting and sum collection
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
        end else if (load) begin
            a_sh      <= bus.a;
            b_sh      <= bus.b;
            sum_sh    <= '0;
            carry_reg <= bus.cin;
            cnt       <= '0;
        end else if (shift_en) begin
            a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh    <= {fa_s, sum_sh[WIDTH-1:1]};
            carry_reg <= fa_cout;
            cnt       <= cnt + CNT_W'(1);
        end
    end

    // sum/cout follow the collection registers and so hold through IDLE
    assign bus.sum  = sum_sh;
    assign bus.cout = carry_reg;
    assign fa_a     = a_sh[0];
    assign fa_b     = b_sh[0];
    assign fa_cin   = carry_reg;
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer that drives one external full_adder cell: a combinational 1-bit a/b/cin → s/cout block.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Feeds the full_adder cell one bit pair per clock, LSB first, through a registered carry loop.
- Collects the sum bits and presents the WIDTH-bit sum and carry-out on a valid/ready output. This trades latency for area next to the ripple adder path.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  initial carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  final carry-out.
- busy  output  1  high in SHIFT or DONE.
- fa_a  output  1  to full_adder a.
- fa_b  output  1  to full_adder b.
- fa_cin  output  1  to full_adder cin.
- fa_s  input  1  from full_adder s.
- fa_cout  input  1  from full_adder cout.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high, sampled only on rising clk.
- Reset values: state=IDLE; a_sh, b_sh, sum_sh = 0; carry_reg = 0; cnt = 0.
- Output values at reset: in_ready=1, out_valid=0, sum=0, cout=0, busy=0, fa_a=fa_b=fa_cin=0.
- fa_a = a_sh[0], fa_b = b_sh[0], fa_cin = carry_reg. These are driven purely from registers, so there is no combinational path from the block's inputs to the fa_* outputs.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready: a_sh<=a, b_sh<=b, carry_reg<=cin, cnt<=0, sum_sh<=0, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle:
    - sum_sh <= {fa_s, sum_sh[WIDTH-1:1]}
    - carry_reg <= fa_cout
    - a_sh, b_sh shift right by one with zero fill
    - cnt <= cnt+1
    - when cnt==WIDTH-1, go to DONE.
  - DONE: out_valid=1; sum=sum_sh, cout=carry_reg. Both held stable while out_ready=0. On out_ready=1, go to IDLE; out_valid drops the next cycle.
- Latency: acceptance edge E0 → out_valid high after edge E0+WIDTH, i.e. exactly WIDTH SHIFT cycles.
- Throughput: one result per WIDTH+2 cycles minimum (accept, WIDTH shifts, drain).
- sum and cout retain their last values in IDLE. Only out_valid qualifies them.
- in_valid while busy is ignored: no capture, no state change. Operands are sampled only at the handshake edge. Changes to a/b/cin afterwards have no effect.
- out_ready outside DONE is ignored.
- Wrap-around: the sum is modulo 2^WIDTH; overflow appears only on cout.
- Reset mid-operation, in SHIFT or DONE: aborts the operation; all registers return to reset values on that edge; no out_valid is produced for the aborted operation.
- rst has priority over all handshakes in the same cycle.

Test Plan:
- Basic add: WIDTH=8, a=0x5A, b=0x3C, cin=0 → out_valid exactly 8 cycles after accept; sum=0x96, cout=0. Check fa_a sequence LSB-first: 0,1,0,1,1,0,1,0.
- Carry ripple: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → sum/cout/out_valid stable, in_ready=0. Then out_ready=1 for one cycle → IDLE, in_ready=1 next cycle.
- Busy ignore: start a=0x01, b=0x02; pulse in_valid with a=0xAA, b=0x55 during SHIFT → result sum=0x03, cout=0; no second out_valid.
- Reset mid-op: assert rst at the 4th SHIFT cycle → next cycle all outputs at reset values, in_ready=1. A fresh a=0x10, b=0x20 then yields sum=0x30.
- Back-to-back: two operations with out_ready tied high and in_valid tied high → results 0x96 then 0x30, separated by WIDTH+2 cycles.
